// File: rtl/mult_s_c1x1_16x16_pkg.sv
// Shared widths and the byte sign-extension helper for the configurable-signedness
// 16x16 multiplier slice.
package mult_pkg;

  localparam int A_WIDTH    = 16;
  localparam int B_WIDTH    = 16;
  localparam int C_WIDTH    = 32;
  localparam int LANE_WIDTH = 8;

  // A byte's MSB becomes a sign bit only when sign_en is set; otherwise the byte is zero-extended.
  function automatic logic signed [LANE_WIDTH:0] sext_byte(input logic [LANE_WIDTH-1:0] b,
                                                           input logic sign_en);
    return {sign_en & b[LANE_WIDTH-1], b};
  endfunction

endpackage

// File: rtl/mult_s_c1x1_16x16_if.sv
// Operand/product bundle of the multiplier slice; master drives operands and controls.
interface mult_s_c1x1_16x16_if;
  import mult_pkg::*;

  logic [A_WIDTH-1:0] A;
  logic [B_WIDTH-1:0] B;
  logic               A_sign;
  logic               B_sign;
  logic               HALF_0;
  logic [C_WIDTH-1:0] C;

  modport master (output A, B, A_sign, B_sign, HALF_0, input C);
  modport slave  (input A, B, A_sign, B_sign, HALF_0, output C);

endinterface

// File: rtl/mult_s_c1x1_16x16_lane.sv
// Signed 9x9 partial-product core; four of these build the 16x16 product.
module mul_lane_9x9 (
  input  logic signed [8:0]  a,
  input  logic signed [8:0]  b,
  output logic signed [17:0] p
);

  assign p = a * b;

endmodule

// File: rtl/mult_s_c1x1_16x16.sv
// 16x16 multiplier with per-operand signedness and a dual 8x8 lane mode; one-cycle latency.
module mult_s_c1x1_16x16
  import mult_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  mult_s_c1x1_16x16_if.slave     bus
);

  logic               a_lo_sen, b_lo_sen;
  logic signed [8:0]  a_lo, a_hi, b_lo, b_hi;
  logic signed [17:0] pp_ll, pp_lh, pp_hl, pp_hh;
  logic [C_WIDTH-1:0] full_sum;
  logic [C_WIDTH-1:0] c_p0;
  logic [C_WIDTH-1:0] c_p1;

  // Low bytes only carry a sign in dual mode; high bytes carry it in both modes.
  assign a_lo_sen = bus.A_sign & ~bus.HALF_0;
  assign b_lo_sen = bus.B_sign & ~bus.HALF_0;

  assign a_lo = sext_byte(bus.A[LANE_WIDTH-1:0],       a_lo_sen);
  assign a_hi = sext_byte(bus.A[A_WIDTH-1:LANE_WIDTH], bus.A_sign);
  assign b_lo = sext_byte(bus.B[LANE_WIDTH-1:0],       b_lo_sen);
  assign b_hi = sext_byte(bus.B[B_WIDTH-1:LANE_WIDTH], bus.B_sign);

  mul_lane_9x9 u_ll (.a(a_lo), .b(b_lo), .p(pp_ll));
  mul_lane_9x9 u_lh (.a(a_lo), .b(b_hi), .p(pp_lh));
  mul_lane_9x9 u_hl (.a(a_hi), .b(b_lo), .p(pp_hl));
  mul_lane_9x9 u_hh (.a(a_hi), .b(b_hi), .p(pp_hh));

  // Shift-add of sign-extended partials; only the low 32 bits are kept.
  assign full_sum = ({{14{pp_hh[17]}}, pp_hh} << 16)
                  + ({{14{pp_hl[17]}}, pp_hl} << 8)
                  + ({{14{pp_lh[17]}}, pp_lh} << 8)
                  +  {{14{pp_ll[17]}}, pp_ll};

  assign c_p0 = bus.HALF_0 ? full_sum : {pp_hh[15:0], pp_ll[15:0]};

  // Stage p0 -> p1: registered product
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) c_p1 <= '0;
    else        c_p1 <= c_p0;
  end

  assign bus.C = c_p1;

endmodule

// File: tb/tb_mult_s_c1x1_16x16.sv
// Scoreboard bench: stimulus pushes expected products, a monitor checks C each cycle.
module tb_mult_s_c1x1_16x16;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];

  mult_s_c1x1_16x16_if bus ();

  mult_s_c1x1_16x16 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] lane_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic sa, input logic sb);
    longint x, y, p;
    x = sa ? longint'($signed(a)) : longint'(a);
    y = sb ? longint'($signed(b)) : longint'(b);
    p = x * y;
    return p[15:0];
  endfunction

  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                          input logic sa, input logic sb, input logic full);
    longint x, y, p;
    if (full) begin
      x = sa ? longint'($signed(a)) : longint'(a);
      y = sb ? longint'($signed(b)) : longint'(b);
      p = x * y;
      return p[31:0];
    end
    return {lane_ref(a[15:8], b[15:8], sa, sb), lane_ref(a[7:0], b[7:0], sa, sb)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: C=%h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] b,
                       input logic sa, input logic sb, input logic full);
    @(negedge clk);
    bus.A = a; bus.B = b; bus.A_sign = sa; bus.B_sign = sb; bus.HALF_0 = full;
  endtask

  // Directed vector: expectation supplied as a constant
  task automatic issue_k(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic sa, input logic sb, input logic full, input logic [31:0] exp);
    drive(a, b, sa, sb, full);
    exp_q.push_back(exp);
    name_q.push_back(name);
  endtask

  // Random vector: expectation from the reference model
  task automatic issue_r(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic sa, input logic sb, input logic full);
    drive(a, b, sa, sb, full);
    exp_q.push_back(ref_mul(a, b, sa, sb, full));
    name_q.push_back(name);
  endtask

  // Monitor: each capture edge presents the product of the inputs sampled at that edge
  initial begin
    logic [31:0] e;
    string       n;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        check(n, bus.C, e);
      end
    end
  end

  initial begin
    bus.A = '0; bus.B = '0; bus.A_sign = 1'b0; bus.B_sign = 1'b0; bus.HALF_0 = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 check("reset_state", bus.C, 32'h0);
    repeat (2) @(posedge clk);
    #2 check("reset_hold", bus.C, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    issue_k("uu_max",    16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b1, 32'hFFFE0001);
    issue_k("uu_small",  16'h1234, 16'h0010, 1'b0, 1'b0, 1'b1, 32'h00012340);
    issue_k("ss_minmin", 16'h8000, 16'h8000, 1'b1, 1'b1, 1'b1, 32'h40000000);
    issue_k("ss_m1min",  16'hFFFF, 16'h8000, 1'b1, 1'b1, 1'b1, 32'h00008000);
    issue_k("ss_m1x3",   16'hFFFF, 16'h0003, 1'b1, 1'b1, 1'b1, 32'hFFFFFFFD);
    issue_k("su_mixed",  16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b1, 32'hFFFF0001);
    issue_k("us_mixed",  16'h0002, 16'hFFFE, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFC);
    issue_k("dual_uu",   16'h0302, 16'h0504, 1'b0, 1'b0, 1'b0, 32'h000F0008);
    issue_k("dual_ss",   16'hFF80, 16'h0280, 1'b1, 1'b1, 1'b0, 32'hFFFE4000);
    issue_k("dual_uu_max", 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, 32'hFE01FE01);
    issue_k("dual_ss_min", 16'h8080, 16'h8080, 1'b1, 1'b1, 1'b0, 32'h40004000);

    // Asynchronous reset between edges, then recovery
    issue_k("pre_reset", 16'h1234, 16'h0010, 1'b0, 1'b0, 1'b1, 32'h00012340);
    @(posedge clk);
    #3;
    checks++;
    if (bus.C == 32'h0) begin
      errors++;
      $display("FAIL pre_reset_nonzero: C=%h required nonzero", bus.C);
    end
    rst_n = 1'b0;
    #1 check("async_reset", bus.C, 32'h0);
    @(posedge clk);
    #1 check("reset_low_edge", bus.C, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(32'h00012340);
    name_q.push_back("post_reset");

    for (int i = 0; i < 100; i++)
      issue_r("rand_full_uu", 16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 100; i++)
      issue_r("rand_full_ss", 16'($urandom), 16'($urandom), 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 100; i++)
      issue_r("rand_dual", 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: pending=%0d required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
